// File: rtl/alu.sv
// 32-bit execute-stage ALU: add, subtract, negate or pass A through a single shared
// adder, with the result and its zero/negative flags registered one cycle later.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  opcode,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out,
  output logic        Z,
  output logic        N
);

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_SUB   = 3'b001,
    OP_NEG   = 3'b010,
    OP_ADD   = 3'b100,
    OP_PASSA = 3'b111
  } op_e;

  // Two's complement sum of lhs, rhs and carry-in, wrapped modulo 2^DATA_W.
  function automatic logic signed [DATA_W-1:0] wrap_add(
    input logic signed [DATA_W-1:0] lhs,
    input logic signed [DATA_W-1:0] rhs,
    input logic                     cin
  );
    logic signed [DATA_W-1:0] sum;
    sum = lhs + rhs + {{(DATA_W-1){1'b0}}, cin};
    return sum;
  endfunction

  logic signed [DATA_W-1:0] w_a;
  logic signed [DATA_W-1:0] w_b;
  logic signed [DATA_W-1:0] w_lhs;
  logic signed [DATA_W-1:0] w_rhs;
  logic                     w_cin;
  logic                     w_load;
  logic signed [DATA_W-1:0] w_result;

  logic signed [DATA_W-1:0] r_out_p1;
  logic                     r_z_p1;
  logic                     r_n_p1;

  assign w_a = a;
  assign w_b = b;

  // Every arithmetic op maps onto lhs + rhs + cin so one adder serves ADD, SUB and NEG.
  always_comb begin
    w_lhs  = w_a;
    w_rhs  = '0;
    w_cin  = 1'b0;
    w_load = 1'b0;
    case (opcode)
      OP_ADD: begin
        w_rhs  = w_b;
        w_load = 1'b1;
      end
      OP_SUB: begin
        w_rhs  = ~w_b;
        w_cin  = 1'b1;
        w_load = 1'b1;
      end
      OP_NEG: begin
        w_lhs  = '0;
        w_rhs  = ~w_a;
        w_cin  = 1'b1;
        w_load = 1'b1;
      end
      OP_PASSA: begin
        w_load = 1'b1;
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  assign w_result = wrap_add(w_lhs, w_rhs, w_cin);

  // Stage p0 -> p1: result and flags registered together; NOP and reserved opcodes hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_p1 <= '0;
      r_z_p1   <= 1'b1;
      r_n_p1   <= 1'b0;
    end else if (w_load) begin
      r_out_p1 <= w_result;
      r_z_p1   <= (w_result == '0);
      r_n_p1   <= w_result[DATA_W-1];
    end
  end

  assign out = r_out_p1;
  assign Z   = r_z_p1;
  assign N   = r_n_p1;

endmodule

// File: tb/tb_alu.sv
// Directed plus randomised bench for alu: each driven operation pushes its expected
// out/Z/N onto a scoreboard queue, popped and checked one edge later.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [2:0]  opcode;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] out;
  logic        Z;
  logic        N;

  typedef struct {
    string       tag;
    logic [31:0] out;
    logic        z;
    logic        n;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp;
  int          n_fail;
  logic [31:0] m_out;

  alu dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .a      (a),
    .b      (b),
    .out    (out),
    .Z      (Z),
    .N      (N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 entries expected>=1");
      return;
    end
    e = sb_q.pop_front();
    n_cmp++;
    assert (out === e.out) else begin
      n_fail++;
      $error("FAIL %s.out observed=%h expected=%h", e.tag, out, e.out);
    end
    n_cmp++;
    assert (Z === e.z) else begin
      n_fail++;
      $error("FAIL %s.Z observed=%b expected=%b", e.tag, Z, e.z);
    end
    n_cmp++;
    assert (N === e.n) else begin
      n_fail++;
      $error("FAIL %s.N observed=%b expected=%b", e.tag, N, e.n);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] op,
                      input logic [31:0] aa, input logic [31:0] bb, input string tag);
    exp_t e;
    rst    = r;
    opcode = op;
    a      = aa;
    b      = bb;
    if (r) m_out = 32'h0;
    else begin
      case (op)
        3'b100:  m_out = aa + bb;
        3'b001:  m_out = aa - bb;
        3'b010:  m_out = 32'h0 - aa;
        3'b111:  m_out = aa;
        default: m_out = m_out;
      endcase
    end
    e.tag = tag;
    e.out = m_out;
    e.z   = (m_out == 32'h0);
    e.n   = m_out[31];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    m_out  = 32'h0;
    rst    = 1'b1;
    opcode = 3'b000;
    a      = 32'h0;
    b      = 32'h0;
    #2;

    step(1'b1, 3'b100, 32'h1234, 32'h1, "reset");
    step(1'b0, 3'b000, 32'hDEAD, 32'hBEEF, "nop_after_reset");
    step(1'b0, 3'b100, 32'd6, 32'd5, "add_6_5");
    step(1'b0, 3'b010, 32'd6, 32'd5, "neg_6");
    step(1'b0, 3'b001, 32'd6, 32'd5, "sub_6_5");
    step(1'b0, 3'b000, 32'd9, 32'd9, "nop_hold");
    step(1'b0, 3'b111, 32'd6, 32'd5, "passa_6");
    step(1'b0, 3'b001, 32'd6, 32'd6, "sub_equal");
    step(1'b0, 3'b100, 32'h7FFFFFFF, 32'h1, "add_wrap");
    step(1'b0, 3'b010, 32'h80000000, 32'h0, "neg_min");
    step(1'b0, 3'b010, 32'h0, 32'h5, "neg_zero");
    step(1'b0, 3'b001, 32'h0, 32'h1, "sub_underflow");
    step(1'b0, 3'b011, 32'h55, 32'h1, "rsvd_011");
    step(1'b0, 3'b101, 32'h66, 32'h2, "rsvd_101");
    step(1'b0, 3'b110, 32'h77, 32'h3, "rsvd_110");
    step(1'b0, 3'b111, 32'hA5A5A5A5, 32'h0, "passa_neg");
    step(1'b1, 3'b100, 32'h10, 32'h20, "reset_mid");
    step(1'b0, 3'b100, 32'h10, 32'h20, "add_after_reset");

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      step((i == 25) ? 1'b1 : 1'b0, op, $urandom, $urandom, "b2b");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=no_finish expected=finish");
    $fatal(1, "bench timeout");
  end

endmodule
